approx_mult_pipe: RTL

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

---
 rtl/approx_mult_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - two-stage pipelined unsigned multiplier with per-transaction sub-product truncation
// Optional feature macro: APPROX_MULT_STATS_EN (saturating count of output transfers on op_count).
// The product is built from four half-width sub-products. Stage 1 registers the
// (possibly truncated) sub-products, stage 2 registers their weighted sum.

module approx_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   R,
  output logic [15:0]          op_count
);

  localparam int H  = WIDTH / 2;
  localparam int RW = 2 * WIDTH;

  // A sub-product is 2H = WIDTH bits wide; truncation keeps only the bits above TRUNC.
  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << TRUNC;

  // Operand halves
  logic [H-1:0] a_lo, a_hi, b_lo, b_hi;

  // Exact and selected sub-products for the incoming operands
  logic [WIDTH-1:0] ll_exact, lh_exact, hl_exact, hh_exact;
  logic [WIDTH-1:0] ll_sel, lh_sel, hl_sel, hh_sel;

  // Which sub-products are truncated for this transaction
  logic ll_apx, mid_apx, hh_apx;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_ll_q, s1_lh_q, s1_hl_q, s1_hh_q;

  // Stage 2 state
  logic             out_valid_q, out_valid_d;
  logic [RW-1:0]    r_q, r_d;

  // Stage enables
  logic s1_en, s2_en;
  logic out_fire;

  assign a_lo = A[H-1:0];
  assign a_hi = A[WIDTH-1:H];
  assign b_lo = B[H-1:0];
  assign b_hi = B[WIDTH-1:H];

  // Form the four exact sub-products at full sub-product width
  always_comb begin
    ll_exact = WIDTH'(a_lo) * WIDTH'(b_lo);
    lh_exact = WIDTH'(a_lo) * WIDTH'(b_hi);
    hl_exact = WIDTH'(a_hi) * WIDTH'(b_lo);
    hh_exact = WIDTH'(a_hi) * WIDTH'(b_hi);
  end

  // Decode mode: 00 exact, 01 LL only, 10 all but HH, 11 all four truncated
  always_comb begin
    ll_apx  = (mode != 2'b00);
    mid_apx = mode[1];
    hh_apx  = (mode == 2'b11);
  end

  // Apply truncation to the selected sub-products
  always_comb begin
    ll_sel = ll_apx  ? (ll_exact & KEEP_MASK) : ll_exact;
    lh_sel = mid_apx ? (lh_exact & KEEP_MASK) : lh_exact;
    hl_sel = mid_apx ? (hl_exact & KEEP_MASK) : hl_exact;
    hh_sel = hh_apx  ? (hh_exact & KEEP_MASK) : hh_exact;
  end

  // Handshake: stage 2 advances when empty or drained, stage 1 when empty or moving into stage 2
  assign out_fire = out_valid_q && out_ready;
  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;

  // Stage 1 next-state valid
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
    end
  end

  // Stage 1 valid bit with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  // Stage 1 payload: capture the selected sub-products on every input transfer
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s1_ll_q <= ll_sel;
      s1_lh_q <= lh_sel;
      s1_hl_q <= hl_sel;
      s1_hh_q <= hh_sel;
    end
  end

  // Stage 2 next state: weighted sum of the stage 1 sub-products
  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        r_d = {s1_hh_q, {WIDTH{1'b0}}}
            + ((RW'(s1_lh_q) + RW'(s1_hl_q)) << H)
            + RW'(s1_ll_q);
      end
    end
  end

  // Stage 2 registers; R holds its last value whenever nothing new arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
    end
  end

  assign out_valid = out_valid_q;
  assign R         = r_q;

`ifdef APPROX_MULT_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  // Saturating count of output transfers
  always_comb begin
    op_count_d = op_count_q;
    if (out_fire && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
  assign op_count        = 16'h0000;
`endif

endmodule
